inst_fetch_queue: RTL and testbench

Front-end fetch unit for the dual-mode MIPS/Y86 core. It owns the fetch PC and mode, issues aligned 32-bit instruction-memory reads, and buffers the returned bytes. From that buffer it assembles variable-length instructions (MIPS: 4 bytes; Y86: 1–6 bytes) into the 48-bit `inst` word consumed by the translate/decode stage. It sits between instruction memory and the decoder, and accepts redirects from the jump/branch logic.

---
 rtl/ifq_pkg.sv | 28 ++
 rtl/inst_fetch_queue_y86_len_decode.sv | 20 ++
 rtl/inst_fetch_queue.sv | 163 ++++++++++++++++
 tb/tb_inst_fetch_queue.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction fetch queue: memory-FSM states,
// instruction length limits and the Y86 opcode nibbles used by the length decoder.
package ifq_pkg;

  typedef enum logic [1:0] {
    IFQ_IDLE = 2'd0,
    IFQ_REQ  = 2'd1,
    IFQ_WAIT = 2'd2
  } ifq_state_e;

  localparam logic [2:0] IFQ_LEN_MIPS = 3'd4;
  localparam logic [2:0] IFQ_LEN_MAX  = 3'd6;

  localparam logic [3:0] Y86_OP_HALT   = 4'h0;
  localparam logic [3:0] Y86_OP_NOP    = 4'h1;
  localparam logic [3:0] Y86_OP_RRMOVL = 4'h2;
  localparam logic [3:0] Y86_OP_IRMOVL = 4'h3;
  localparam logic [3:0] Y86_OP_RMMOVL = 4'h4;
  localparam logic [3:0] Y86_OP_MRMOVL = 4'h5;
  localparam logic [3:0] Y86_OP_OPL    = 4'h6;
  localparam logic [3:0] Y86_OP_JXX    = 4'h7;
  localparam logic [3:0] Y86_OP_CALL   = 4'h8;
  localparam logic [3:0] Y86_OP_RET    = 4'h9;
  localparam logic [3:0] Y86_OP_PUSHL  = 4'hA;
  localparam logic [3:0] Y86_OP_POPL   = 4'hB;
  localparam logic [3:0] Y86_OP_JMIPS  = 4'hC;

endpackage

// File: rtl/inst_fetch_queue_y86_len_decode.sv
// Combinational Y86 instruction length from the opcode nibble of byte 0.
module y86_len_decode
  import ifq_pkg::*;
(
  input  logic [3:0] i_op,
  output logic [2:0] o_len
);

  always_comb begin
    o_len = 3'd1;
    case (i_op)
      Y86_OP_HALT, Y86_OP_NOP, Y86_OP_RET:                   o_len = 3'd1;
      Y86_OP_RRMOVL, Y86_OP_OPL, Y86_OP_PUSHL, Y86_OP_POPL:  o_len = 3'd2;
      Y86_OP_JXX, Y86_OP_CALL, Y86_OP_JMIPS:                 o_len = 3'd5;
      Y86_OP_IRMOVL, Y86_OP_RMMOVL, Y86_OP_MRMOVL:           o_len = IFQ_LEN_MAX;
      default:                                               o_len = 3'd1;
    endcase
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch front end: issues word reads, buffers bytes and presents MIPS/Y86 instructions.
// Optional build macro IFQ_PERF_EN adds the issued/starve performance counters.
module inst_fetch_queue
  import ifq_pkg::*;
#(
  parameter int DEPTH_WORDS = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        redirect_mode,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [47:0] inst,
  output logic        inst_mode,
  output logic [31:0] inst_pc,
  output logic [31:0] next_inst_pc,
  output logic [31:0] perf_issued,
  output logic [31:0] perf_starve
);

  localparam int CAP   = 4 * DEPTH_WORDS;
  localparam int BUF_W = 8 * CAP;
  localparam int CW    = $clog2(CAP + 1);

  ifq_state_e       r_state, w_state_nxt;
  logic [31:0]      r_pc, r_addr;
  logic             r_mode, r_drop, w_drop_nxt;
  logic [1:0]       r_skip;
  logic [CW-1:0]    r_cnt, w_cnt_base, w_cnt_nxt;
  logic [BUF_W-1:0] r_buf, w_buf_base, w_buf_nxt;
  logic [2:0]       w_y86_len, w_len, w_nbytes;
  logic [31:0]      w_word;
  logic [47:0]      w_inst;
  logic             w_valid, w_pop, w_accept, w_free_ok;

  y86_len_decode u_len (
    .i_op  (r_buf[7:4]),
    .o_len (w_y86_len)
  );

  assign w_len    = r_mode ? w_y86_len : IFQ_LEN_MIPS;
  assign w_valid  = (r_cnt >= CW'(w_len));
  assign w_pop    = w_valid & inst_ready & ~redirect;
  assign w_accept = (r_state == IFQ_WAIT) & imem_rvalid & ~r_drop & ~redirect;

  // Buffer update: pop first, then append the (possibly trimmed) word behind what is left.
  always_comb begin
    w_word     = imem_rdata >> {r_skip, 3'b000};
    w_nbytes   = 3'd4 - {1'b0, r_skip};
    w_buf_base = w_pop ? (r_buf >> {w_len, 3'b000}) : r_buf;
    w_cnt_base = w_pop ? (r_cnt - CW'(w_len)) : r_cnt;
    w_buf_nxt  = w_buf_base;
    w_cnt_nxt  = w_cnt_base;
    if (w_accept) begin
      w_buf_nxt = w_buf_base | (BUF_W'(w_word) << {w_cnt_base, 3'b000});
      w_cnt_nxt = w_cnt_base + CW'(w_nbytes);
    end
    if (redirect) begin
      w_buf_nxt = '0;
      w_cnt_nxt = '0;
    end
  end

  // Room is judged on the post-update count, so a response cycle can chain straight into
  // the next request and a redirect can request from its new address one cycle later.
  assign w_free_ok = (w_cnt_nxt <= CW'(CAP - 4));

  always_comb begin
    w_state_nxt = r_state;
    w_drop_nxt  = r_drop;
    case (r_state)
      IFQ_IDLE: if (w_free_ok) w_state_nxt = IFQ_REQ;
      IFQ_REQ: begin
        if (imem_gnt) begin
          w_state_nxt = IFQ_WAIT;
          w_drop_nxt  = redirect;
        end
      end
      IFQ_WAIT: begin
        if (imem_rvalid) begin
          w_drop_nxt  = 1'b0;
          w_state_nxt = w_free_ok ? IFQ_REQ : IFQ_IDLE;
        end else if (redirect) begin
          w_drop_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IFQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IFQ_IDLE;
      r_drop  <= 1'b0;
      r_cnt   <= '0;
      r_buf   <= '0;
      r_pc    <= '0;
      r_mode  <= 1'b0;
      r_addr  <= '0;
      r_skip  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_drop  <= w_drop_nxt;
      r_cnt   <= w_cnt_nxt;
      r_buf   <= w_buf_nxt;
      if (redirect) begin
        r_pc   <= redirect_pc;
        r_mode <= redirect_mode;
        r_addr <= {redirect_pc[31:2], 2'b00};
        r_skip <= redirect_pc[1:0];
      end else begin
        if (w_pop) r_pc <= next_inst_pc;
        if (w_accept) begin
          r_addr <= r_addr + 32'd4;
          r_skip <= 2'd0;
        end
      end
    end
  end

  always_comb begin
    w_inst = '0;
    for (int k = 0; k < int'(IFQ_LEN_MAX); k++) begin
      if (3'(k) < w_len) w_inst[8*k +: 8] = r_buf[8*k +: 8];
    end
  end

  assign imem_req     = (r_state == IFQ_REQ);
  assign imem_addr    = r_addr;
  assign inst_valid   = w_valid;
  assign inst         = w_inst;
  assign inst_mode    = r_mode;
  assign inst_pc      = r_pc;
  assign next_inst_pc = w_valid ? (r_pc + {29'd0, w_len}) : r_pc;

`ifdef IFQ_PERF_EN
  logic [31:0] r_perf_issued, r_perf_starve;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_perf_issued <= '0;
      r_perf_starve <= '0;
    end else begin
      if (w_valid & inst_ready)  r_perf_issued <= r_perf_issued + 32'd1;
      if (~w_valid & inst_ready) r_perf_starve <= r_perf_starve + 32'd1;
    end
  end

  assign perf_issued = r_perf_issued;
  assign perf_starve = r_perf_starve;
`else
  assign perf_issued = '0;
  assign perf_starve = '0;
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: table of redirect vectors plus hand sequences.
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        resetn, redirect, redirect_mode, imem_req, imem_gnt, imem_rvalid;
  logic        inst_valid, inst_ready, inst_mode;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, inst_pc, next_inst_pc;
  logic [31:0] perf_issued, perf_starve;
  logic [47:0] inst;

  always #5 clk = ~clk;

  inst_fetch_queue #(.DEPTH_WORDS(3)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .redirect_mode(redirect_mode),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .inst         (inst),
    .inst_mode    (inst_mode),
    .inst_pc      (inst_pc),
    .next_inst_pc (next_inst_pc),
    .perf_issued  (perf_issued),
    .perf_starve  (perf_starve)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mem [0:127];
  int          lat = 0;
  bit          pend = 1'b0;
  logic [31:0] pend_addr;
  int          pend_wait;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Memory: grants any request immediately, answers 1+lat cycles after the grant.
  initial begin
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      if (pend) begin
        if (pend_wait == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem[pend_addr[8:2]];
          pend        = 1'b0;
        end else begin
          pend_wait--;
        end
      end
      imem_gnt = 1'b0;
      if (imem_req === 1'b1 && !pend) begin
        imem_gnt  = 1'b1;
        pend      = 1'b1;
        pend_addr = imem_addr;
        pend_wait = lat;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic do_redirect(input logic [31:0] pc, input logic m);
    @(negedge clk);
    redirect      = 1'b1;
    redirect_pc   = pc;
    redirect_mode = m;
    @(negedge clk);
    redirect = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int max);
    for (int i = 0; i < max && inst_valid !== 1'b1; i++) @(negedge clk);
    chk({name, " valid"}, inst_valid, 1);
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        mode;
    logic [47:0] inst;
    logic [31:0] nxt;
  } vec_t;

  vec_t vecs [17];

  initial begin
    int          got;
    logic [31:0] epc;
    logic [31:0] a;

    resetn = 1'b0; redirect = 1'b0; redirect_pc = '0; redirect_mode = 1'b0; inst_ready = 1'b0;

    for (int i = 0; i < 128; i++) mem[i] = '0;
    mem[0]   = 32'h20080005; mem[1]  = 32'h8C090010; mem[2]  = 32'hAC0A0020;
    mem[4]   = 32'h11111111; mem[8]  = 32'h22222222;
    mem[16]  = 32'h000000F0; mem[20] = 32'h7766AB20; mem[21] = 32'hDDCCBBAA;
    mem[24]  = 32'h00000090; mem[28] = 32'h44332280; mem[29] = 32'h000000EE;
    mem[30]  = 32'h04030250; mem[31] = 32'h00000605; mem[34] = 32'h55443340;
    mem[35]  = 32'h00007766; mem[36] = 32'h030201C0; mem[37] = 32'h00000004;
    mem[40]  = 32'h000012B0; mem[41] = 32'h000000D7;
    mem[64]  = 32'hF230ABCD; mem[65] = 32'h12345678; mem[127] = 32'hCAFEF00D;
    // Nop region: byte at address a is 0x10 | a[3:0], so lost/duplicated bytes show up.
    for (int w = 96; w < 112; w++) begin
      a = 32'(w * 4);
      mem[w] = {4'h1, 4'(a + 3), 4'h1, 4'(a + 2), 4'h1, 4'(a + 1), 4'h1, a[3:0]};
    end

    vecs[0]  = '{32'h0000_0004, 1'b0, 48'h0000_8C09_0010, 32'h0000_0008};
    vecs[1]  = '{32'h0000_0102, 1'b1, 48'h1234_5678_F230, 32'h0000_0108};
    vecs[2]  = '{32'h0000_0040, 1'b1, 48'h0000_0000_00F0, 32'h0000_0041};
    vecs[3]  = '{32'h0000_0050, 1'b1, 48'h0000_0000_AB20, 32'h0000_0052};
    vecs[4]  = '{32'h0000_0051, 1'b1, 48'h0000_0000_66AB, 32'h0000_0053};
    vecs[5]  = '{32'h0000_0052, 1'b1, 48'h0000_0000_7766, 32'h0000_0054};
    vecs[6]  = '{32'h0000_0053, 1'b1, 48'h00DD_CCBB_AA77, 32'h0000_0058};
    vecs[7]  = '{32'h0000_0060, 1'b1, 48'h0000_0000_0090, 32'h0000_0061};
    vecs[8]  = '{32'h0000_0061, 1'b1, 48'h0000_0000_0000, 32'h0000_0062};
    vecs[9]  = '{32'h0000_0070, 1'b1, 48'h00EE_4433_2280, 32'h0000_0075};
    vecs[10] = '{32'h0000_0078, 1'b1, 48'h0605_0403_0250, 32'h0000_007E};
    vecs[11] = '{32'h0000_0088, 1'b1, 48'h7766_5544_3340, 32'h0000_008E};
    vecs[12] = '{32'h0000_0090, 1'b1, 48'h0004_0302_01C0, 32'h0000_0095};
    vecs[13] = '{32'h0000_00A0, 1'b1, 48'h0000_0000_12B0, 32'h0000_00A2};
    vecs[14] = '{32'h0000_00A4, 1'b1, 48'h0000_0000_00D7, 32'h0000_00A5};
    vecs[15] = '{32'hFFFF_FFFC, 1'b0, 48'h0000_CAFE_F00D, 32'h0000_0000};
    vecs[16] = '{32'h0000_0000, 1'b0, 48'h0000_2008_0005, 32'h0000_0004};

    @(negedge clk);
    chk("rst imem_req", imem_req, 0);
    chk("rst imem_addr", imem_addr, 0);
    chk("rst inst_valid", inst_valid, 0);
    chk("rst inst", inst, 0);
    chk("rst inst_pc", inst_pc, 0);
    chk("rst next_inst_pc", next_inst_pc, 0);
    chk("rst inst_mode", inst_mode, 0);
    chk("rst perf_issued", perf_issued, 0);
    chk("rst perf_starve", perf_starve, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("boot imem_req", imem_req, 1);
    chk("boot imem_addr", imem_addr, 0);
    wait_valid("boot", 10);
    chk("boot inst", inst, 48'h0000_2008_0005);
    chk("boot inst_pc", inst_pc, 0);
    chk("boot next_inst_pc", next_inst_pc, 4);
    chk("boot inst_mode", inst_mode, 0);

    for (int i = 0; i < 17; i++) begin
      do_redirect(vecs[i].pc, vecs[i].mode);
      wait_valid($sformatf("vec%0d", i), 20);
      chk($sformatf("vec%0d inst", i), inst, vecs[i].inst);
      chk($sformatf("vec%0d inst_pc", i), inst_pc, vecs[i].pc);
      chk($sformatf("vec%0d next_inst_pc", i), next_inst_pc, vecs[i].nxt);
      chk($sformatf("vec%0d inst_mode", i), inst_mode, vecs[i].mode);
    end

    // Held instruction with a full buffer: no more requests, outputs frozen.
    repeat (6) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk("sat imem_req", imem_req, 0);
      chk("sat inst", inst, 48'h0000_2008_0005);
      chk("sat inst_pc", inst_pc, 0);
      @(negedge clk);
    end
    inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("drain%0d valid", i), inst_valid, 1);
      chk($sformatf("drain%0d inst_pc", i), inst_pc, 32'(4 * i));
      chk($sformatf("drain%0d inst", i), inst, {16'h0, mem[i]});
      @(negedge clk);
    end
    inst_ready = 1'b0;
    repeat (8) @(negedge clk);

    // Redirect latency from an idle, full queue.
    redirect = 1'b1; redirect_pc = 32'h40; redirect_mode = 1'b1;
    @(negedge clk);
    redirect = 1'b0;
    chk("lat t+1 imem_req", imem_req, 1);
    chk("lat t+1 imem_addr", imem_addr, 32'h40);
    chk("lat t+1 inst_valid", inst_valid, 0);
    @(negedge clk);
    chk("lat t+2 inst_valid", inst_valid, 0);
    @(negedge clk);
    chk("lat t+3 inst_valid", inst_valid, 1);
    chk("lat t+3 inst", inst, 48'hF0);
    chk("lat t+3 next_inst_pc", next_inst_pc, 32'h41);
    repeat (10) @(negedge clk);

    // Redirect while a slow read is outstanding: its data must be dropped.
    lat = 3;
    do_redirect(32'h10, 1'b0);
    chk("drop first req", imem_req, 1);
    @(negedge clk);
    lat = 0;
    redirect = 1'b1; redirect_pc = 32'h20; redirect_mode = 1'b0;
    @(negedge clk);
    redirect = 1'b0;
    chk("drop no second req", imem_req, 0);
    wait_valid("drop", 20);
    chk("drop inst_pc", inst_pc, 32'h20);
    chk("drop inst", inst, 48'h0000_2222_2222);
    chk("drop next_inst_pc", next_inst_pc, 32'h24);

    // Nop stream with the decoder always ready.
    do_redirect(32'h181, 1'b1);
    inst_ready = 1'b1;
    got = 0;
    epc = 32'h181;
    for (int c = 0; c < 150 && got < 20; c++) begin
      if (inst_valid === 1'b1) begin
        chk($sformatf("nop%0d inst", got), inst, {40'h0, 4'h1, epc[3:0]});
        chk($sformatf("nop%0d inst_pc", got), inst_pc, epc);
        chk($sformatf("nop%0d next_inst_pc", got), next_inst_pc, epc + 1);
        epc = epc + 1;
        got++;
      end
      @(negedge clk);
    end
    chk("nop count", got, 20);
    inst_ready = 1'b0;

    // Asynchronous reset with a read in flight; the late response lands during reset.
    lat = 2;
    do_redirect(32'h30, 1'b1);
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("mid-rst imem_req", imem_req, 0);
    chk("mid-rst imem_addr", imem_addr, 0);
    chk("mid-rst inst_valid", inst_valid, 0);
    chk("mid-rst inst_pc", inst_pc, 0);
    chk("mid-rst next_inst_pc", next_inst_pc, 0);
    chk("mid-rst inst", inst, 0);
    chk("mid-rst inst_mode", inst_mode, 0);
    repeat (5) @(negedge clk);
    lat = 0;
    resetn = 1'b1;
    wait_valid("post-rst", 10);
    chk("post-rst inst", inst, 48'h0000_2008_0005);
    chk("post-rst inst_pc", inst_pc, 0);
    chk("post-rst inst_mode", inst_mode, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
